// File: rtl/dmg_decoder_sequencer_pkg.sv
// Shared types, constants and the Decoder1 pair encoder for the sequencer.
// Optional feature macro used by the top: DMG_HALT_BUG_EN.
package dmg_seq_pkg;

  localparam int         STATE_W = 3;
  localparam logic [7:0] OP_CB   = 8'hCB;
  localparam logic [7:0] OP_HALT = 8'h76;

  typedef logic [STATE_W-1:0] step_t;

  typedef struct packed {
    logic [7:0] ir;
    step_t      state;
    logic       cb;
    logic       intr;
    logic       halted;
    logic       err;
  } seq_regs_t;

  // Complementary-pair image of the sequencer state for Decoder1.
  function automatic logic [25:0] seq_encode_a(
    input logic       intr,
    input logic       cb,
    input logic [7:0] ir,
    input step_t      st
  );
    logic [25:0] v;
    v[1] = intr;
    v[0] = ~intr;
    v[3] = cb;
    v[2] = ~cb;
    for (int k = 0; k < 8; k++) begin
      v[5+2*k] = ir[7-k];
      v[4+2*k] = ~ir[7-k];
    end
    v[21] = st[2];
    v[20] = ~st[2];
    v[23] = st[1];
    v[22] = ~st[1];
    v[25] = st[0];
    v[24] = ~st[0];
    return v;
  endfunction

endpackage

// File: rtl/dmg_decoder_sequencer_if.sv
// Bus between the data latch / decoders and the M-cycle sequencer.
// master drives decoder requests, slave is the sequencer.
interface dmg_seq_if;
  logic        mcyc;
  logic [7:0]  ir_din;
  logic        op_end;
  logic        cond_fail;
  logic        halt_req;
  logic        int_req;
  logic        ime;
  logic [25:0] a;
  logic [7:0]  ir;
  logic [2:0]  state;
  logic        cb_mode;
  logic        intr_dispatch;
  logic        halted;
  logic        pc_inc_inh;
  logic        seq_err;

  modport master (
    output mcyc, ir_din, op_end, cond_fail,
    output halt_req, int_req, ime,
    input  a, ir, state, cb_mode,
    input  intr_dispatch, halted,
    input  pc_inc_inh, seq_err
  );

  modport slave (
    input  mcyc, ir_din, op_end, cond_fail,
    input  halt_req, int_req, ime,
    output a, ir, state, cb_mode,
    output intr_dispatch, halted,
    output pc_inc_inh, seq_err
  );
endinterface

// File: rtl/dmg_seq_a_encoder.sv
// Combinational complementary-pair encoder for the Decoder1 a[25:0] bus.
// Also reused standalone by decoder benches.
module dmg_seq_a_encoder
  import dmg_seq_pkg::*;
(
  input  logic        i_intr,
  input  logic        i_cb,
  input  logic [7:0]  i_ir,
  input  step_t       i_state,
  output logic [25:0] o_a
);

  // Pure function of the registered state, no input paths.
  always_comb begin
    o_a = seq_encode_a(i_intr, i_cb, i_ir, i_state);
  end

endmodule

// File: rtl/dmg_decoder_sequencer.sv
// M-cycle sequencer: IR, CB page, interrupt dispatch, HALT, step counter.
// Define DMG_HALT_BUG_EN to enable the one-M-cycle PC increment inhibit.
module dmg_decoder_sequencer
  import dmg_seq_pkg::*;
#(
  parameter int         MAX_STATE = 7,
  parameter logic [7:0] IR_RESET  = 8'h00
) (
  input logic      CLK,
  input logic      nRESET,
  dmg_seq_if.slave bus
);

  localparam step_t LAST = step_t'(MAX_STATE);

  seq_regs_t   r_q;
  seq_regs_t   w_d;
  logic        w_bnd;
  logic        w_r1;
  logic        w_r2;
  logic        w_r3;
  logic        w_r4;
  logic        w_r5;
  logic        w_r6;
  logic        w_wake;
  logic [25:0] w_a;

  // Rule selects, made mutually exclusive in priority order.
  always_comb begin
    w_bnd  = bus.op_end | bus.cond_fail;
    w_r1   = r_q.halted;
    w_r2   = !r_q.halted && w_bnd && !r_q.intr
             && !r_q.cb && (r_q.ir == OP_CB);
    w_r3   = !r_q.halted && w_bnd && !w_r2
             && bus.halt_req && !bus.int_req;
    w_r4   = !r_q.halted && w_bnd && !w_r2 && !w_r3
             && bus.int_req && bus.ime;
    w_r5   = !r_q.halted && w_bnd && !w_r2
             && !w_r3 && !w_r4;
    w_r6   = !r_q.halted && !w_bnd;
    w_wake = w_r1 && bus.int_req && !bus.ime;
  end

  // State register; everything advances only on an M-cycle strobe.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_q.ir     <= IR_RESET;
      r_q.state  <= '0;
      r_q.cb     <= 1'b0;
      r_q.intr   <= 1'b0;
      r_q.halted <= 1'b0;
      r_q.err    <= 1'b0;
    end else if (bus.mcyc) begin
      r_q <= w_d;
    end
  end

  // Next-state selection for one M-cycle boundary.
  always_comb begin
    w_d = r_q;
    unique case (1'b1)
      w_r1: begin
        if (bus.int_req) begin
          w_d.halted = 1'b0;
          w_d.state  = '0;
          if (bus.ime) begin
            w_d.intr = 1'b1;
          end else begin
            w_d.ir = bus.ir_din;
            w_d.cb = 1'b0;
          end
        end
      end
      w_r2: begin
        w_d.cb    = 1'b1;
        w_d.ir    = bus.ir_din;
        w_d.state = '0;
      end
      w_r3: begin
        w_d.halted = 1'b1;
        w_d.state  = '0;
      end
      w_r4: begin
        w_d.intr  = 1'b1;
        w_d.cb    = 1'b0;
        w_d.state = '0;
      end
      w_r5: begin
        w_d.ir    = bus.ir_din;
        w_d.cb    = 1'b0;
        w_d.intr  = 1'b0;
        w_d.state = '0;
      end
      w_r6: begin
        if (r_q.state == LAST) begin
          w_d.err = 1'b1;
        end else begin
          w_d.state = r_q.state + step_t'(1);
        end
      end
      default: begin
      end
    endcase
  end

  dmg_seq_a_encoder u_enc (
    .i_intr  (r_q.intr),
    .i_cb    (r_q.cb),
    .i_ir    (r_q.ir),
    .i_state (r_q.state),
    .o_a     (w_a)
  );

  // Outputs come straight from registers.
  always_comb begin
    bus.a             = w_a;
    bus.ir            = r_q.ir;
    bus.state         = r_q.state;
    bus.cb_mode       = r_q.cb;
    bus.intr_dispatch = r_q.intr;
    bus.halted        = r_q.halted;
    bus.seq_err       = r_q.err;
  end

`ifdef DMG_HALT_BUG_EN
  logic r_pc_inh;

  // Inhibit lasts from the HALT wake-up until the next M-cycle strobe.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_pc_inh <= 1'b0;
    end else if (bus.mcyc) begin
      r_pc_inh <= w_wake;
    end
  end

  assign bus.pc_inc_inh = r_pc_inh;
`else
  logic w_unused;

  assign w_unused       = w_wake;
  assign bus.pc_inc_inh = 1'b0;
`endif

endmodule
